coin_change_arbiter: RTL

- Round-robin arbiter and sequencer that shares one coin-change engine among NUM_REQ requesters (kiosk ports).
- Accepts one request at a time and issues its 6-bit amount to the engine as a one-cycle in_valid pulse.
- Captures the engine's ten/five/one coin counts and returns them to the winning requester over a valid/ready response channel.
- Sits between the kiosk front-ends and the change engine and guarantees the engine only sees in_valid while it is idle.

---
 rtl/coin_pkg.sv | 18 +
 rtl/rr_picker.sv | 28 ++
 rtl/coin_change_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared types and constants for the coin-change arbiter slice.
package coin_pkg;

   localparam int AMT_W     = 6;
   localparam int CNT_W     = 3;

   localparam int COIN_TEN  = 10;
   localparam int COIN_FIVE = 5;
   localparam int COIN_ONE  = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request after the pointer, with wrap.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      // Offset 1 first so the last-served requester has lowest priority.
      for (int k = 1; k <= NUM_REQ; k++) begin
         automatic int j = (int'(i_ptr) + k) % NUM_REQ;
         if (!o_any && i_req[j]) begin
            o_any      = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/coin_change_arbiter.sv
// Shares one coin-change engine among NUM_REQ requesters, one transaction at a time.
//   state | meaning
//   IDLE  | pick a requester, latch its amount and index
//   ISSUE | one-cycle start pulse to the engine
//   WAIT  | wait for engine result or timeout
//   RESP  | hold response until accepted
module coin_change_arbiter
   import coin_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*AMT_W-1:0] req_amount,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     eng_in_valid,
   output logic [AMT_W-1:0]         eng_in_coin,
   input  logic                     eng_out_valid,
   input  logic [CNT_W-1:0]         eng_ten,
   input  logic [CNT_W-1:0]         eng_five,
   input  logic [CNT_W-1:0]         eng_one,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [ID_W-1:0]          resp_id,
   output logic [CNT_W-1:0]         resp_ten,
   output logic [CNT_W-1:0]         resp_five,
   output logic [CNT_W-1:0]         resp_one,
   output logic                     resp_err
);

   localparam int TW = $clog2(TIMEOUT);

   arb_state_t       r_state;
   logic [ID_W-1:0]  r_ptr;
   logic [ID_W-1:0]  r_id;
   logic [TW-1:0]    r_wait_cnt;
   logic             r_eng_in_valid;
   logic [AMT_W-1:0] r_eng_in_coin;
   logic             r_resp_valid;
   logic [CNT_W-1:0] r_ten;
   logic [CNT_W-1:0] r_five;
   logic [CNT_W-1:0] r_one;
   logic             r_err;

   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_idx;
   logic               w_any;
   logic [AMT_W-1:0]   w_amt;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_amt = req_amount[int'(w_idx)*AMT_W +: AMT_W];

   // Grant is only visible in IDLE; masked during reset so every output reads 0.
   assign req_ready    = (r_state == IDLE && !rst) ? w_grant : '0;
   assign eng_in_valid = r_eng_in_valid;
   assign eng_in_coin  = r_eng_in_coin;
   assign resp_valid   = r_resp_valid;
   assign resp_id      = r_id;
   assign resp_ten     = r_ten;
   assign resp_five    = r_five;
   assign resp_one     = r_one;
   assign resp_err     = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_ptr          <= ID_W'(NUM_REQ - 1);
         r_id           <= '0;
         r_wait_cnt     <= '0;
         r_eng_in_valid <= 1'b0;
         r_eng_in_coin  <= '0;
         r_resp_valid   <= 1'b0;
         r_ten          <= '0;
         r_five         <= '0;
         r_one          <= '0;
         r_err          <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_id           <= w_idx;
                  r_eng_in_coin  <= w_amt;
                  r_eng_in_valid <= 1'b1;
                  r_state        <= ISSUE;
               end
            end
            ISSUE: begin
               r_eng_in_valid <= 1'b0;
               r_wait_cnt     <= '0;
               r_state        <= WAIT;
            end
            WAIT: begin
               r_wait_cnt <= r_wait_cnt + 1'b1;
               // A result arriving on the timeout cycle still counts as success.
               if (eng_out_valid) begin
                  r_ten        <= eng_ten;
                  r_five       <= eng_five;
                  r_one        <= eng_one;
                  r_err        <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_state      <= RESP;
               end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
                  r_ten        <= '0;
                  r_five       <= '0;
                  r_one        <= '0;
                  r_err        <= 1'b1;
                  r_resp_valid <= 1'b1;
                  r_state      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_ptr        <= r_id;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
